sudoku_cell_stack: RTL and testbench

Parametrised Sudoku cell with a snapshot stack for backtracking. Holds one cell's solved value and its candidate set for boards of `DIGITS` symbols. Supports the same write, mask and singleton-latch operations as the first-generation cell, and adds a `DEPTH`-deep LIFO of {value, candidates} so the grid controller can guess and then undo. Instantiated once per cell inside the grid array; the controller drives all handshakes.

---
 rtl/sudoku_pkg.sv | 27 ++
 rtl/sudoku_cell_stack_if.sv | 46 ++++
 rtl/sudoku_snap_stack.sv | 51 +++++
 rtl/sudoku_cell_stack.sv | 113 +++++++++++
 tb/tb_sudoku_cell_stack.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku cell family: register addresses and
// digit-vector helpers sized for the largest supported board (16 symbols).
package sudoku_pkg;

    localparam int MAX_DIGITS = 16;
    localparam int MAX_CW     = $clog2(MAX_DIGITS + 1);

    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_CAND  = 2'd1;
    localparam logic [1:0] ADDR_LEVEL = 2'd2;

    typedef logic [MAX_DIGITS-1:0] digit_vec_t;

    // Callers zero-extend their DIGITS-wide vector, so one body serves every board size.
    function automatic logic is_onehot(input digit_vec_t v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [MAX_CW-1:0] popcount(input digit_vec_t v);
        logic [MAX_CW-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_DIGITS; i++)
            n = n + MAX_CW'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/sudoku_cell_stack_if.sv
// Controller-to-cell bus. hidden_mask exists only when SUDOKU_HIDDEN_SINGLE_EN is defined.
interface sudoku_cell_stack_if #(
    parameter int DIGITS = 9,
    parameter int DEPTH  = 8
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DIGITS + 1);

    logic [DIGITS-1:0] wdata;
    logic [DIGITS-1:0] rdata;
    logic [1:0]        address;
    logic              we;
    logic              latch_singleton;
    logic              push;
    logic              pop;
`ifdef SUDOKU_HIDDEN_SINGLE_EN
    logic [DIGITS-1:0] hidden_mask;
`endif
    logic              is_singleton;
    logic              is_illegal;
    logic              solved;
    logic [CW-1:0]     cand_count;
    logic [LW-1:0]     stack_level;
    logic              stack_full;
    logic              stack_empty;
    logic              err;

    modport master (
        output wdata, address, we, latch_singleton, push, pop,
`ifdef SUDOKU_HIDDEN_SINGLE_EN
        output hidden_mask,
`endif
        input  rdata, is_singleton, is_illegal, solved, cand_count,
        input  stack_level, stack_full, stack_empty, err
    );

    modport slave (
        input  wdata, address, we, latch_singleton, push, pop,
`ifdef SUDOKU_HIDDEN_SINGLE_EN
        input  hidden_mask,
`endif
        output rdata, is_singleton, is_illegal, solved, cand_count,
        output stack_level, stack_full, stack_empty, err
    );

endinterface

// File: rtl/sudoku_snap_stack.sv
// DEPTH-entry LIFO of cell snapshots. Storage is not reset; only the level is.
module sudoku_snap_stack #(
    parameter int  W     = 18,
    parameter int  DEPTH = 8,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          err
);
    logic [W-1:0]  mem [DEPTH];
    logic [LW-1:0] lvl;
    logic          do_push;
    logic          do_pop;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign full    = (lvl == LW'(DEPTH));
    assign empty   = (lvl == '0);
    // Simultaneous push and pop cancel each other and count as an error.
    assign do_push = push && !pop && !full;
    assign do_pop  = pop && !push && !empty;
    assign err     = (push && pop) || (push && !pop && full) || (pop && !push && empty);
    assign wr_idx  = IW'(lvl);
    assign rd_idx  = IW'(lvl - 1'b1);
    assign dout    = mem[rd_idx];
    assign level   = lvl;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_idx] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset)
            lvl <= '0;
        else if (do_push)
            lvl <= lvl + 1'b1;
        else if (do_pop)
            lvl <= lvl - 1'b1;
    end

endmodule

// File: rtl/sudoku_cell_stack.sv
// One sudoku cell (value + candidate set) with a snapshot stack for backtracking.
// Optional hidden-single latching is enabled by defining SUDOKU_HIDDEN_SINGLE_EN.
module sudoku_cell_stack
    import sudoku_pkg::*;
#(
    parameter int DIGITS = 9,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    sudoku_cell_stack_if.slave  bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(DIGITS + 1);

    logic [DIGITS-1:0]   value;
    logic [DIGITS-1:0]   cand;
    logic [2*DIGITS-1:0] snap;
    logic [LW-1:0]       level;
    logic                full;
    logic                empty;
    logic                stk_err;
    logic                err;
    logic                pop_ok;
    logic                wr_ok;
    logic                bad_write;
    logic                naked;
`ifdef SUDOKU_HIDDEN_SINGLE_EN
    logic [DIGITS-1:0]   hidden_val;
    logic                hidden;
`endif

    sudoku_snap_stack #(.W(2*DIGITS), .DEPTH(DEPTH)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (bus.push),
        .pop   (bus.pop),
        .din   ({value, cand}),
        .dout  (snap),
        .level (level),
        .full  (full),
        .empty (empty),
        .err   (stk_err)
    );

    assign pop_ok    = bus.pop && !bus.push && !empty;
    assign wr_ok     = (bus.wdata == '0) || is_onehot(MAX_DIGITS'(bus.wdata));
    // Any pop attempt drops the write, so a rejected value write only counts without one.
    assign bad_write = !bus.pop && bus.we && (bus.address == ADDR_VALUE) && !wr_ok;
    assign naked     = (value == '0) && is_onehot(MAX_DIGITS'(cand));
`ifdef SUDOKU_HIDDEN_SINGLE_EN
    assign hidden_val = cand & bus.hidden_mask;
    assign hidden     = (value == '0) && !is_onehot(MAX_DIGITS'(cand))
                        && is_onehot(MAX_DIGITS'(hidden_val));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
            cand  <= '1;
            err   <= 1'b0;
        end else begin
            if (pop_ok) begin
                value <= snap[2*DIGITS-1:DIGITS];
                cand  <= snap[DIGITS-1:0];
            end else if (!bus.pop) begin
                if (bus.we) begin
                    case (bus.address)
                        ADDR_VALUE: if (wr_ok) begin
                            value <= bus.wdata;
                            cand  <= (bus.wdata == '0) ? '1 : '0;
                        end
                        ADDR_CAND: cand <= (value == '0) ? (cand & bus.wdata) : '0;
                        default: ;
                    endcase
                end else if (bus.latch_singleton) begin
                    if (naked) begin
                        value <= cand;
                        cand  <= '0;
                    end
`ifdef SUDOKU_HIDDEN_SINGLE_EN
                    else if (hidden) begin
                        value <= hidden_val;
                        cand  <= '0;
                    end
`endif
                end
            end
            if (stk_err || bad_write)
                err <= 1'b1;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.address)
            ADDR_VALUE: bus.rdata = value;
            ADDR_CAND:  bus.rdata = cand;
            ADDR_LEVEL: bus.rdata = DIGITS'(level);
            default:    bus.rdata = '0;
        endcase
    end

    assign bus.is_singleton = is_onehot(MAX_DIGITS'(cand));
    assign bus.is_illegal   = (value == '0) && (cand == '0);
    assign bus.solved       = (value != '0);
    assign bus.cand_count   = CW'(popcount(MAX_DIGITS'(cand)));
    assign bus.stack_level  = level;
    assign bus.stack_full   = full;
    assign bus.stack_empty  = empty;
    assign bus.err          = err;

endmodule

// File: tb/tb_sudoku_cell_stack.sv
// Scoreboard bench for sudoku_cell_stack (DIGITS=9, DEPTH=2): expectations are queued
// per operation and drained against the cell's outputs after the clock edge.
module tb_sudoku_cell_stack;
    import sudoku_pkg::*;

    localparam int DIGITS = 9;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sudoku_cell_stack_if #(.DIGITS(DIGITS), .DEPTH(DEPTH)) bus();

    sudoku_cell_stack #(.DIGITS(DIGITS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {S_VAL, S_CAND, S_LVLRD, S_A3, S_CNT, S_SING, S_ILL, S_SOLVED,
                      S_LEVEL, S_FULL, S_EMPTY, S_ERR} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ex(input string tag, input sel_e sel, input logic [31:0] exp);
        sbq.push_back('{tag, sel, exp});
    endtask

    task automatic observe(input sel_e sel, output logic [31:0] v);
        v = '0;
        case (sel)
            S_VAL:    begin bus.address = ADDR_VALUE; #1; v = 32'(bus.rdata); end
            S_CAND:   begin bus.address = ADDR_CAND;  #1; v = 32'(bus.rdata); end
            S_LVLRD:  begin bus.address = ADDR_LEVEL; #1; v = 32'(bus.rdata); end
            S_A3:     begin bus.address = 2'd3;       #1; v = 32'(bus.rdata); end
            S_CNT:    v = 32'(bus.cand_count);
            S_SING:   v = 32'(bus.is_singleton);
            S_ILL:    v = 32'(bus.is_illegal);
            S_SOLVED: v = 32'(bus.solved);
            S_LEVEL:  v = 32'(bus.stack_level);
            S_FULL:   v = 32'(bus.stack_full);
            S_EMPTY:  v = 32'(bus.stack_empty);
            S_ERR:    v = 32'(bus.err);
            default:  v = '0;
        endcase
    endtask

    task automatic drain();
        exp_t        x;
        logic [31:0] got;
        while (sbq.size() != 0) begin
            x = sbq.pop_front();
            observe(x.sel, got);
            chk(x.tag, got, x.exp);
        end
    endtask

    // One strobe cycle: drive, take the edge, release strobes 1ns later.
    task automatic op(input logic w, input logic [1:0] a, input logic [DIGITS-1:0] d,
                      input logic lt, input logic ps, input logic pp);
        bus.we = w; bus.address = a; bus.wdata = d;
        bus.latch_singleton = lt; bus.push = ps; bus.pop = pp;
        @(posedge clk); #1;
        bus.we = 1'b0; bus.latch_singleton = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.we = 1'b0; bus.address = '0; bus.wdata = '0;
        bus.latch_singleton = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
`ifdef SUDOKU_HIDDEN_SINGLE_EN
        bus.hidden_mask = '0;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        ex("rst_val", S_VAL, 0);   ex("rst_cand", S_CAND, 9'h1FF); ex("rst_lvl", S_LEVEL, 0);
        ex("rst_empty", S_EMPTY, 1); ex("rst_err", S_ERR, 0);      ex("rst_a3", S_A3, 0);
        drain();

        op(1, ADDR_VALUE, 9'h000, 0, 0, 0);
        ex("w0_cand", S_CAND, 9'h1FF); ex("w0_cnt", S_CNT, 9); ex("w0_sing", S_SING, 0);
        ex("w0_empty", S_EMPTY, 1);    ex("w0_solved", S_SOLVED, 0);
        drain();

        op(1, ADDR_LEVEL, 9'h1FF, 0, 0, 0);
        ex("w2_val", S_VAL, 0); ex("w2_cand", S_CAND, 9'h1FF); ex("w2_lvlrd", S_LVLRD, 0);
        drain();

        op(1, ADDR_CAND, 9'h010, 0, 0, 0);
        ex("mask_cand", S_CAND, 9'h010); ex("mask_sing", S_SING, 1); ex("mask_cnt", S_CNT, 1);
        drain();

        op(0, ADDR_VALUE, 9'h000, 1, 0, 0);
        ex("latch_val", S_VAL, 9'h010); ex("latch_cand", S_CAND, 0); ex("latch_solved", S_SOLVED, 1);
        drain();

        op(1, ADDR_VALUE, 9'h003, 0, 0, 0);
        ex("badw_val", S_VAL, 9'h010); ex("badw_err", S_ERR, 1);
        drain();

        // save-and-guess then undo
        do_reset();
        op(1, ADDR_CAND, 9'h0F0, 0, 0, 0);
        op(1, ADDR_VALUE, 9'h004, 0, 1, 0);
        ex("guess_val", S_VAL, 9'h004); ex("guess_cand", S_CAND, 0);
        ex("guess_lvl", S_LEVEL, 1);    ex("guess_lvlrd", S_LVLRD, 1);
        drain();
        op(0, ADDR_VALUE, 9'h000, 0, 0, 1);
        ex("undo_val", S_VAL, 0); ex("undo_cand", S_CAND, 9'h0F0);
        ex("undo_lvl", S_LEVEL, 0); ex("undo_err", S_ERR, 0);
        drain();

        // overflow with concurrent write, then underflow
        op(0, ADDR_VALUE, 9'h000, 0, 1, 0);
        op(0, ADDR_VALUE, 9'h000, 0, 1, 0);
        ex("full_err0", S_ERR, 0); ex("full_flag", S_FULL, 1);
        drain();
        op(1, ADDR_CAND, 9'h030, 0, 1, 0);
        ex("ovf_lvl", S_LEVEL, 2); ex("ovf_err", S_ERR, 1); ex("ovf_cand", S_CAND, 9'h030);
        drain();
        op(0, ADDR_VALUE, 9'h000, 0, 0, 1);
        ex("pop1_lvl", S_LEVEL, 1); ex("pop1_cand", S_CAND, 9'h0F0); ex("pop1_full", S_FULL, 0);
        drain();
        op(0, ADDR_VALUE, 9'h000, 0, 0, 1);
        op(0, ADDR_VALUE, 9'h000, 0, 0, 1);
        ex("unf_lvl", S_LEVEL, 0); ex("unf_empty", S_EMPTY, 1);
        ex("unf_err", S_ERR, 1);   ex("unf_cand", S_CAND, 9'h0F0);
        drain();

        // reset discards snapshots
        do_reset();
        op(1, ADDR_CAND, 9'h0F0, 0, 0, 0);
        op(0, ADDR_VALUE, 9'h000, 0, 1, 0);
        ex("pre_rst_lvl", S_LEVEL, 1);
        drain();
        do_reset();
        ex("mid_rst_lvl", S_LEVEL, 0); ex("mid_rst_cand", S_CAND, 9'h1FF); ex("mid_rst_err", S_ERR, 0);
        drain();

        // push+pop together: nothing happens except err
        op(1, ADDR_CAND, 9'h0F0, 0, 0, 0);
        op(0, ADDR_VALUE, 9'h000, 0, 1, 0);
        op(1, ADDR_CAND, 9'h010, 0, 1, 1);
        ex("pp_lvl", S_LEVEL, 1); ex("pp_cand", S_CAND, 9'h0F0); ex("pp_err", S_ERR, 1);
        drain();

        // push with latch, then pop with latch
        do_reset();
        op(1, ADDR_CAND, 9'h010, 0, 0, 0);
        op(0, ADDR_VALUE, 9'h000, 0, 1, 0);
        op(0, ADDR_VALUE, 9'h000, 1, 1, 0);
        ex("pl_val", S_VAL, 9'h010); ex("pl_cand", S_CAND, 0); ex("pl_lvl", S_LEVEL, 2);
        drain();
        op(0, ADDR_VALUE, 9'h000, 1, 0, 1);
        ex("ppl_val", S_VAL, 0); ex("ppl_cand", S_CAND, 9'h010);
        ex("ppl_lvl", S_LEVEL, 1); ex("ppl_sing", S_SING, 1);
        drain();

        op(1, ADDR_CAND, 9'h000, 0, 0, 0);
        ex("ill_flag", S_ILL, 1); ex("ill_cnt", S_CNT, 0);
        drain();

        // hidden single
        do_reset();
        op(1, ADDR_CAND, 9'h0C0, 0, 0, 0);
`ifdef SUDOKU_HIDDEN_SINGLE_EN
        bus.hidden_mask = 9'h040;
        op(0, ADDR_VALUE, 9'h000, 1, 0, 0);
        ex("hid_val", S_VAL, 9'h040); ex("hid_cand", S_CAND, 0);
        drain();
        do_reset();
        op(1, ADDR_CAND, 9'h0C0, 0, 0, 0);
        bus.hidden_mask = 9'h0C0;
`endif
        op(0, ADDR_VALUE, 9'h000, 1, 0, 0);
        ex("nohid_val", S_VAL, 0); ex("nohid_cand", S_CAND, 9'h0C0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
